// File: rtl/mc_control_if.sv
// mc_control_if: control-unit to datapath signal bundle
interface mc_control_if;
   logic [31:0] instr;
   logic        equal;
   logic        PC_WE;
   logic        IR_WE;
   logic        branch;
   logic        j;
   logic        jr;
   logic        GRF_WE;
   logic [1:0]  sel_rt_rd_31;
   logic [1:0]  sel_alu_dm_pc4;
   logic        sel_zero_sign;
   logic        sel_imm32_rt;
   logic [2:0]  ALUOp;
   logic        DM_RE;
   logic        DM_WE;
   logic        DM_isSigned;
   logic [2:0]  DM_opBytes;
   logic [2:0]  phase;
   logic        instr_done;
   modport master (
      input  instr, equal,
      output PC_WE, IR_WE, branch, j, jr, GRF_WE, sel_rt_rd_31, sel_alu_dm_pc4,
             sel_zero_sign, sel_imm32_rt, ALUOp, DM_RE, DM_WE, DM_isSigned,
             DM_opBytes, phase, instr_done
   );
   modport slave (
      output instr, equal,
      input  PC_WE, IR_WE, branch, j, jr, GRF_WE, sel_rt_rd_31, sel_alu_dm_pc4,
             sel_zero_sign, sel_imm32_rt, ALUOp, DM_RE, DM_WE, DM_isSigned,
             DM_opBytes, phase, instr_done
   );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath
module mc_control (
   input  logic         clk,
   input  logic         reset,
   mc_control_if.master bus
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
   state_t state_q, state_d;
   logic [5:0] op, funct;
   logic rtype, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_nop;
   logic pc_we, ir_we, br, jmp, jreg, grf_we, sgn, imm, dm_re, dm_we, done;
   logic [1:0] wa, wd;
   logic [2:0] alu, ph;
   logic unused_instr;
   assign op           = bus.instr[31:26];
   assign funct        = bus.instr[5:0];
   assign unused_instr = ^bus.instr[25:6];
   assign rtype   = op == 6'b000000;
   assign is_addu = rtype && funct == 6'b100001;
   assign is_subu = rtype && funct == 6'b100011;
   assign is_jr   = rtype && funct == 6'b001000;
   assign is_ori  = op == 6'b001101;
   assign is_lui  = op == 6'b001111;
   assign is_lw   = op == 6'b100011;
   assign is_sw   = op == 6'b101011;
   assign is_beq  = op == 6'b000100;
   assign is_j    = op == 6'b000010;
   assign is_jal  = op == 6'b000011;
   assign is_nop  = !(is_addu | is_subu | is_jr | is_ori | is_lui | is_lw | is_sw | is_beq | is_j | is_jal);
   // state register; an active-low reset always lands in FETCH
   always_ff @(posedge clk) begin
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   end
   // next state and per-phase control lines; only beq's PC_WE looks at an input
   always_comb begin
      state_d = FETCH;
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      br      = 1'b0;
      jmp     = 1'b0;
      jreg    = 1'b0;
      grf_we  = 1'b0;
      wa      = 2'b00;
      wd      = 2'b00;
      sgn     = 1'b0;
      imm     = 1'b0;
      alu     = 3'b000;
      dm_re   = 1'b0;
      dm_we   = 1'b0;
      done    = 1'b0;
      case (state_q)
         FETCH: begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = DECODE;
         end
         DECODE: begin
            pc_we   = is_j | is_jal | is_jr;
            jmp     = is_j | is_jal;
            jreg    = is_jr;
            grf_we  = is_jal;
            wa      = is_jal ? 2'b10 : 2'b00;
            wd      = is_jal ? 2'b10 : 2'b00;
            done    = is_j | is_jal | is_jr | is_nop;
            state_d = done ? FETCH : EXEC;
         end
         EXEC: begin
            alu     = (is_subu | is_beq) ? 3'b001 : is_ori ? 3'b010 : is_lui ? 3'b011 : 3'b000;
            imm     = is_ori | is_lui | is_lw | is_sw;
            sgn     = is_lw | is_sw;
            br      = is_beq;
            pc_we   = is_beq & bus.equal;
            done    = is_beq;
            state_d = is_beq ? FETCH : (is_lw | is_sw) ? MEM : WB;
         end
         MEM: begin
            sgn     = 1'b1;
            imm     = 1'b1;
            dm_re   = is_lw;
            dm_we   = is_sw;
            done    = is_sw;
            state_d = is_sw ? FETCH : WB;
         end
         WB: begin
            grf_we  = 1'b1;
            wa      = (is_addu | is_subu) ? 2'b01 : 2'b00;
            wd      = is_lw ? 2'b01 : 2'b00;
            dm_re   = is_lw;
            done    = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end
   assign ph = (state_q <= WB) ? state_q : 3'b000;
   assign bus.PC_WE          = reset & pc_we;
   assign bus.IR_WE          = reset & ir_we;
   assign bus.branch         = reset & br;
   assign bus.j              = reset & jmp;
   assign bus.jr             = reset & jreg;
   assign bus.GRF_WE         = reset & grf_we;
   assign bus.sel_rt_rd_31   = reset ? wa : 2'b00;
   assign bus.sel_alu_dm_pc4 = reset ? wd : 2'b00;
   assign bus.sel_zero_sign  = reset & sgn;
   assign bus.sel_imm32_rt   = reset & imm;
   assign bus.ALUOp          = reset ? alu : 3'b000;
   assign bus.DM_RE          = reset & dm_re;
   assign bus.DM_WE          = reset & dm_we;
   assign bus.DM_isSigned    = 1'b0;
   assign bus.DM_opBytes     = (reset & (dm_re | dm_we)) ? 3'b100 : 3'b000;
   assign bus.phase          = reset ? ph : 3'b000;
   assign bus.instr_done     = reset & done;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed per-cycle scoreboard for mc_control
module tb_mc_control;
   typedef struct packed {
      logic [2:0] phase;
      logic pc_we, ir_we, branch, j, jr, grf_we;
      logic [1:0] wa, wd;
      logic sgn, imm;
      logic [2:0] alu;
      logic dm_re, dm_we, dm_signed;
      logic [2:0] ob;
      logic done;
   } vec_t;
   typedef struct {
      vec_t  v;
      string name;
   } exp_t;
   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];
   mc_control_if bus();
   mc_control dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic vec_t z(input logic [2:0] ph);
      vec_t v;
      v = '0;
      v.phase = ph;
      return v;
   endfunction
   function automatic vec_t ex(input logic [2:0] alu, input logic sgn, input logic imm);
      vec_t v;
      v = z(3'd2);
      v.alu = alu;
      v.sgn = sgn;
      v.imm = imm;
      return v;
   endfunction
   function automatic vec_t wb(input logic [1:0] wa, input logic [1:0] wd, input logic re);
      vec_t v;
      v = z(3'd4);
      v.grf_we = 1'b1;
      v.wa = wa;
      v.wd = wd;
      v.dm_re = re;
      v.ob = re ? 3'b100 : 3'b000;
      v.done = 1'b1;
      return v;
   endfunction
   function automatic vec_t mem(input logic is_sw);
      vec_t v;
      v = z(3'd3);
      v.sgn = 1'b1;
      v.imm = 1'b1;
      v.dm_re = !is_sw;
      v.dm_we = is_sw;
      v.ob = 3'b100;
      v.done = is_sw;
      return v;
   endfunction
   function automatic vec_t beq(input logic eq);
      vec_t v;
      v = ex(3'b001, 1'b0, 1'b0);
      v.branch = 1'b1;
      v.pc_we = eq;
      v.done = 1'b1;
      return v;
   endfunction
   function automatic vec_t dec(input logic jj, input logic jal, input logic jr);
      vec_t v;
      v = z(3'd1);
      v.pc_we = jj | jal | jr;
      v.j = jj | jal;
      v.jr = jr;
      v.grf_we = jal;
      v.wa = jal ? 2'b10 : 2'b00;
      v.wd = jal ? 2'b10 : 2'b00;
      v.done = 1'b1;
      return v;
   endfunction
   task automatic push(input string nm, input vec_t v);
      exp_t e;
      e.v = v;
      e.name = nm;
      exp_q.push_back(e);
   endtask
   task automatic cyc(input logic rn, input string nm, input vec_t v);
      @(posedge clk);
      #1;
      reset = rn;
      push(nm, v);
   endtask
   task automatic fetch(input logic [31:0] ins, input logic eq, input string nm);
      vec_t v;
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.instr = ins;
      bus.equal = eq;
      v = z(3'd0);
      v.pc_we = 1'b1;
      v.ir_we = 1'b1;
      push({nm, "/F"}, v);
   endtask
   initial begin
      exp_t e;
      vec_t act;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            act.phase = bus.phase;
            act.pc_we = bus.PC_WE;
            act.ir_we = bus.IR_WE;
            act.branch = bus.branch;
            act.j = bus.j;
            act.jr = bus.jr;
            act.grf_we = bus.GRF_WE;
            act.wa = bus.sel_rt_rd_31;
            act.wd = bus.sel_alu_dm_pc4;
            act.sgn = bus.sel_zero_sign;
            act.imm = bus.sel_imm32_rt;
            act.alu = bus.ALUOp;
            act.dm_re = bus.DM_RE;
            act.dm_we = bus.DM_WE;
            act.dm_signed = bus.DM_isSigned;
            act.ob = bus.DM_opBytes;
            act.done = bus.instr_done;
            checks++;
            if (act !== e.v) begin
               errors++;
               $display("FAIL %s: got %07h expected %07h", e.name, act, e.v);
            end
         end
      end
   end
   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      reset = 1'b0;
      bus.instr = 32'h0;
      bus.equal = 1'b0;
      repeat (3) cyc(1'b0, "reset", z(3'd0));
      fetch(32'h00221821, 1'b0, "addu");
      cyc(1'b1, "addu/D", z(3'd1));
      cyc(1'b1, "addu/E", ex(3'b000, 1'b0, 1'b0));
      cyc(1'b1, "addu/W", wb(2'b01, 2'b00, 1'b0));
      fetch(32'h00221823, 1'b0, "subu");
      cyc(1'b1, "subu/D", z(3'd1));
      cyc(1'b1, "subu/E", ex(3'b001, 1'b0, 1'b0));
      cyc(1'b1, "subu/W", wb(2'b01, 2'b00, 1'b0));
      fetch(32'h8C220004, 1'b0, "lw");
      cyc(1'b1, "lw/D", z(3'd1));
      cyc(1'b1, "lw/E", ex(3'b000, 1'b1, 1'b1));
      cyc(1'b1, "lw/M", mem(1'b0));
      cyc(1'b1, "lw/W", wb(2'b00, 2'b01, 1'b1));
      fetch(32'hAC220004, 1'b0, "sw");
      cyc(1'b1, "sw/D", z(3'd1));
      cyc(1'b1, "sw/E", ex(3'b000, 1'b1, 1'b1));
      cyc(1'b1, "sw/M", mem(1'b1));
      fetch(32'h10220003, 1'b1, "beq1");
      cyc(1'b1, "beq1/D", z(3'd1));
      cyc(1'b1, "beq1/E", beq(1'b1));
      fetch(32'h10220003, 1'b0, "beq0");
      cyc(1'b1, "beq0/D", z(3'd1));
      cyc(1'b1, "beq0/E", beq(1'b0));
      fetch(32'h0C000010, 1'b0, "jal");
      cyc(1'b1, "jal/D", dec(1'b0, 1'b1, 1'b0));
      fetch(32'h08000010, 1'b0, "j");
      cyc(1'b1, "j/D", dec(1'b1, 1'b0, 1'b0));
      fetch(32'h03E00008, 1'b0, "jr");
      cyc(1'b1, "jr/D", dec(1'b0, 1'b0, 1'b1));
      fetch(32'h00000000, 1'b0, "nop");
      cyc(1'b1, "nop/D", dec(1'b0, 1'b0, 1'b0));
      fetch(32'h00221820, 1'b1, "add");
      cyc(1'b1, "add/D", dec(1'b0, 1'b0, 1'b0));
      fetch(32'hFFFFFFFF, 1'b1, "illegal");
      cyc(1'b1, "illegal/D", dec(1'b0, 1'b0, 1'b0));
      fetch(32'h3C011234, 1'b0, "lui");
      cyc(1'b1, "lui/D", z(3'd1));
      cyc(1'b1, "lui/E", ex(3'b011, 1'b0, 1'b1));
      cyc(1'b1, "lui/W", wb(2'b00, 2'b00, 1'b0));
      fetch(32'h34220005, 1'b0, "ori");
      cyc(1'b1, "ori/D", z(3'd1));
      cyc(1'b1, "ori/E", ex(3'b010, 1'b0, 1'b1));
      cyc(1'b0, "ori/W_reset", z(3'd0));
      fetch(32'h34220005, 1'b0, "ori2");
      cyc(1'b1, "ori2/D", z(3'd1));
      cyc(1'b1, "ori2/E", ex(3'b010, 1'b0, 1'b1));
      cyc(1'b1, "ori2/W", wb(2'b00, 2'b00, 1'b0));
      fetch(32'h8C220004, 1'b0, "lw_rst");
      cyc(1'b1, "lw_rst/D", z(3'd1));
      cyc(1'b1, "lw_rst/E", ex(3'b000, 1'b1, 1'b1));
      cyc(1'b0, "lw_rst/M_reset", z(3'd0));
      fetch(32'h08000010, 1'b0, "j2");
      cyc(1'b1, "j2/D", dec(1'b1, 1'b0, 1'b0));
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
